// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-back arbiter.
// Owns the single write port of the register file. Single-cycle ALU results
// always win the port. Long-latency results (mul/div, loads) wait in a small
// FIFO and drain on cycles the ALU leaves free. A per-register pending
// scoreboard lets decode stall on operands that have not been written back.
module regfile_writeback_arbiter #(
  parameter int DEPTH = 4,   // long-latency FIFO entries, power of 2, >= 2
  parameter int WIDTH = 32,  // data width
  parameter int AW    = 5    // register address width
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   AluValid,
  input  logic [AW-1:0]          AluRW,
  input  logic [WIDTH-1:0]       AluData,
  input  logic                   LongValid,
  input  logic [AW-1:0]          LongRW,
  input  logic [WIDTH-1:0]       LongData,
  output logic                   LongReady,
  input  logic                   IssueValid,
  input  logic [AW-1:0]          IssueRW,
  input  logic [AW-1:0]          RA,
  input  logic [AW-1:0]          RB,
  output logic                   HazardA,
  output logic                   HazardB,
  output logic                   RegWr,
  output logic [AW-1:0]          RW,
  output logic [WIDTH-1:0]       BusW,
  output logic [31:0]            Busy,
  output logic [$clog2(DEPTH):0] FifoCount
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FullCount = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   CountOne  = (PW + 1)'(1);
  localparam logic [PW-1:0] PtrOne    = PW'(1);

  // FIFO storage: destination and data kept side by side per entry.
  logic [AW-1:0]    fifoRw   [DEPTH];
  logic [WIDTH-1:0] fifoData [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;

  logic             aluReq;
  logic             pushEn;
  logic             popEn;
  logic [AW-1:0]    headRw;
  logic [WIDTH-1:0] headData;
  logic [31:0]      setVec;
  logic [31:0]      clrVec;

  // A write to $0 is not a request at all, so it never blocks a FIFO pop.
  assign aluReq = AluValid && (AluRW != '0);

  // Ready depends only on registered occupancy: a full FIFO refuses a push
  // even on a cycle where it also pops.
  assign LongReady = (FifoCount < FullCount);

  // $0 transfers complete the handshake but are never stored.
  assign pushEn = LongValid && LongReady && (LongRW != '0);

  // Pop uses registered occupancy, so an entry pushed into an empty FIFO
  // cannot leave on the same edge.
  assign popEn = !aluReq && (FifoCount != '0);

  assign headRw   = fifoRw[rdPtr];
  assign headData = fifoData[rdPtr];

  // Per-register set/clear requests for the scoreboard; register 0 never busy.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : gBusyReq
      if (gi == 0) begin : gZero
        assign setVec[gi] = 1'b0;
        assign clrVec[gi] = 1'b0;
      end else begin : gReg
        assign setVec[gi] = IssueValid && (IssueRW == AW'(gi));
        assign clrVec[gi] = popEn && (headRw == AW'(gi));
      end
    end
  endgenerate

  // Hazards look at the registered scoreboard; address 0 is never a hazard.
  assign HazardA = (RA != '0) && Busy[RA];
  assign HazardB = (RB != '0) && Busy[RB];

  // FIFO entry storage; no reset needed since the pointers define validity.
  always_ff @(posedge Clk) begin
    if (!Rst && pushEn) begin
      fifoRw[wrPtr]   <= LongRW;
      fifoData[wrPtr] <= LongData;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      FifoCount <= '0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + PtrOne;
      if (popEn)  rdPtr <= rdPtr + PtrOne;
      case ({pushEn, popEn})
        2'b10:   FifoCount <= FifoCount + CountOne;
        2'b01:   FifoCount <= FifoCount - CountOne;
        default: FifoCount <= FifoCount;
      endcase
    end
  end

  // Write-port arbitration: ALU first, then FIFO head; address/data hold when idle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      RegWr <= 1'b0;
      RW    <= '0;
      BusW  <= '0;
    end else if (aluReq) begin
      RegWr <= 1'b1;
      RW    <= AluRW;
      BusW  <= AluData;
    end else if (popEn) begin
      RegWr <= 1'b1;
      RW    <= headRw;
      BusW  <= headData;
    end else begin
      RegWr <= 1'b0;
    end
  end

  // Scoreboard update: an issue to a register wins over its same-edge retirement.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Busy <= '0;
    end else begin
      Busy <= (Busy & ~clrVec) | setVec;
    end
  end

endmodule
